// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised FIFO family.
package fifo_pkg;

    // Classification of a rejected access; convenient for scoreboards and monitors.
    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UDF  = 2'd2
    } fifo_err_t;

    // Ceiling log2, never less than 1 so an address port always has a bit.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 32'sd0;
        span   = 32'sd1;
        while (span < value) begin
            span   = span * 32'sd2;
            result = result + 32'sd1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end else begin
            result = result;
        end
        return result;
    endfunction

    // Occupancy counter width: one extra bit so a completely full FIFO is representable.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: registered write, asynchronous read, no reset on contents.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [clog2(DEPTH)-1:0]    waddr,
    input  logic [DATA_SIZE-1:0]       wdata,
    input  logic [clog2(DEPTH)-1:0]    raddr,
    output logic [DATA_SIZE-1:0]       rdata
);

    logic [DATA_SIZE-1:0] mem_r [DEPTH];

    // Store the write word on the rising edge; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// optional first-word-fall-through read and overflow/underflow reporting.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (32'sd1 <<< ADDR_WIDTH) - 32'sd2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_SIZE-1:0]  rdata,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error,
    output logic                  ovf_sticky,
    output logic                  udf_sticky
);

    localparam int DEPTH = 32'sd1 <<< ADDR_WIDTH;
    localparam int CNT_W = cnt_width(ADDR_WIDTH);

    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]      CNT_AE   = CNT_W'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1'b1);

    // Threshold ordering must make sense, otherwise the flags are meaningless.
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
        $fatal(1, "param_fifo: thresholds require AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  error_r;
    logic                  ovf_r;
    logic                  udf_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  wr_rej_s;
    logic                  rd_rej_s;
    logic [DATA_SIZE-1:0]  mem_rdata_s;

    // Flags decode straight from the registered count so they track it in the same cycle.
    assign full         = (count_r == CNT_FULL);
    assign empty        = (count_r == {CNT_W{1'b0}});
    assign almost_full  = (count_r >= CNT_AF);
    assign almost_empty = (count_r <= CNT_AE);
    assign count        = count_r;
    assign error        = error_r;
    assign ovf_sticky   = ovf_r;
    assign udf_sticky   = udf_r;

    // Accept/reject decisions; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        wr_rej_s = 1'b0;
        rd_rej_s = 1'b0;
        if (rd_en && !empty) begin
            rd_acc_s = 1'b1;
        end else begin
            rd_acc_s = 1'b0;
        end
        if (wr_en && (!full || rd_acc_s)) begin
            wr_acc_s = 1'b1;
        end else begin
            wr_acc_s = 1'b0;
        end
        wr_rej_s = wr_en & ~wr_acc_s;
        rd_rej_s = rd_en & ~rd_acc_s;
    end

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (wdata),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // One-cycle error pulse plus sticky status; a new rejection beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_r <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            error_r <= wr_rej_s | rd_rej_s;
            ovf_r   <= wr_rej_s | (ovf_r & ~clr_err);
            udf_r   <= rd_rej_s | (udf_r & ~clr_err);
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly from storage whenever the FIFO holds data.
        assign rdata    = mem_rdata_s;
        assign rd_valid = ~empty;
    end else begin : g_regd
        logic [DATA_SIZE-1:0] rdata_r;
        logic                 rd_valid_r;

        // Capture the popped word; valid strobes for exactly one cycle per accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_r    <= {DATA_SIZE{1'b0}};
                rd_valid_r <= 1'b0;
            end else begin
                if (rd_acc_s) begin
                    rdata_r <= mem_rdata_s;
                end
                rd_valid_r <= rd_acc_s;
            end
        end

        assign rdata    = rdata_r;
        assign rd_valid = rd_valid_r;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO, successor to the fixed 8-bit FIFO. Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and an optional first-word-fall-through (FWFT) read mode. Adds a per-cycle error pulse plus sticky overflow/underflow status with explicit clear. Sits between any producer/consumer pair in a single clock domain.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on rdata while not empty

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
wdata  in  DATA_SIZE  write data
wr_en  in  1  write request
rd_en  in  1  read request
clr_err  in  1  synchronous clear of sticky error flags
rdata  out  DATA_SIZE  read data
rd_valid  out  1  rdata holds a valid popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
error  out  1  one-cycle pulse on rejected access
ovf_sticky  out  1  write rejected since last clear
udf_sticky  out  1  read rejected since last clear

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rdata=0, rd_valid=0, error=0, ovf_sticky=0, udf_sticky=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Pointers: ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally. count is a separate ADDR_WIDTH+1 register.
- Write accept: wr_acc = wr_en & (!full | rd_acc). Accepted write stores wdata at wr_ptr on the edge and increments wr_ptr.
- Read accept: rd_acc = rd_en & !empty. Accepted read increments rd_ptr.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous rd_en and wr_en when full: both accepted; write lands in the freed slot; count stays DEPTH; no error.
- Simultaneous rd_en and wr_en when empty: write accepted, read rejected (underflow); count becomes 1.
- Rejected write (wr_en & full & !rd_acc): data dropped; error=1 next cycle for one cycle; ovf_sticky set.
- Rejected read (rd_en & empty): error=1 next cycle for one cycle; udf_sticky set. rdata holds its previous value.
- Sticky flags: set has priority over clr_err in the same cycle. Otherwise clr_err clears both on the next edge.
- FWFT=0: on rd_acc, rdata <= mem[rd_ptr] at that edge; rd_valid=1 for the following cycle only, else 0. Latency is 1 cycle.
- FWFT=1: rdata = mem[rd_ptr] combinationally; rd_valid = !empty. rd_en pops the displayed word. A word written into an empty FIFO is visible on the cycle after the write edge.
- full, empty, almost_full, almost_empty are combinational decodes of the registered count. They are valid in the same cycle as count.
- Elaboration check: AE_THRESH < AF_THRESH <= DEPTH, else fatal.

Decomposition:
- Package fifo_pkg holds:
  - function clog2
  - count-width helper localparam scheme (CNT_W = ADDR_WIDTH+1)
  - enum fifo_err_t {ERR_NONE, ERR_OVF, ERR_UDF} for bench/scoreboard use
- One sub-module, fifo_mem: simple dual-port array, DATA_SIZE x DEPTH, registered write, asynchronous read. The FWFT=0 output register lives in param_fifo.

Test Plan:
1. Reset, then write 4 words 0xA1,0xB2,0xC3,0xD4; read 3 (FWFT=0) -> rdata A1,B2,C3 one cycle after each rd_en with rd_valid=1; count 4 -> 1; almost_empty=1 at count 2 and 1.
2. Write 16 words 0x00..0x0F, then a 17th (0xFF) -> full=1 and count=16; 0xFF dropped; error pulses 1 cycle; ovf_sticky=1. Reading 16 words returns 0x00..0x0F.
3. rd_en on empty FIFO -> error pulse, udf_sticky=1, count stays 0. Pulse clr_err -> both stickies 0 next cycle.
4. Fill to 16, then rd_en=wr_en=1 for 20 cycles with incrementing data -> count stays 16, no error, output order preserved across pointer wrap.
5. FWFT=1: write 0x5A into empty FIFO -> next cycle rdata=0x5A and rd_valid=1 with no rd_en. rd_en pops it, then empty=1 and rd_valid=0.
6. Write 8 words, assert rst_n low mid-stream between edges -> all outputs reach reset values immediately. After release, empty=1 and count=0.
